// File: rtl/sdr_burst_data_path_if.sv
// sdr_burst_data_path_if
// Bundles the signals between the SDRAM data path, the APB slave and the
// DQ pad wrapper.
//   APB write side : wvalid, wdata, wbe (write FIFO push), wready
//   APB read side  : rvalid, rdata (read FIFO head), rready (pop)
//   DQ pad side    : dq_out, dq_oe, dqm (driven), dq_in (sampled)
// The "slave" modport is the data path's view; "master" is the view of
// everything around it (APB slave plus pad wrapper).
interface sdr_burst_data_path_if #(
  parameter int DW = 16
);
  localparam int BW = DW / 8;

  logic          wvalid;
  logic [DW-1:0] wdata;
  logic [BW-1:0] wbe;
  logic          wready;

  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rready;

  logic [DW-1:0] dq_out;
  logic          dq_oe;
  logic [DW-1:0] dq_in;
  logic [BW-1:0] dqm;

  modport slave (
    input  wvalid, wdata, wbe, rready, dq_in,
    output wready, rvalid, rdata, dq_out, dq_oe, dqm
  );

  modport master (
    output wvalid, wdata, wbe, rready, dq_in,
    input  wready, rvalid, rdata, dq_out, dq_oe, dqm
  );
endinterface

// File: rtl/sdr_burst_data_path.sv
// sdr_burst_data_path
// SDRAM data path with burst support. APB write words are buffered in a
// write FIFO and streamed onto DQ as a BL-beat burst after wr_start (WRITEA);
// BL beats are captured from DQ into a read FIFO CL cycles after rd_start
// (READA).
// Ports:
//   pclk, preset        clock, asynchronous active-high reset
//   wr_start, rd_start  1-cycle start pulses from the command FSM
//   wr_burst_ok         idle and at least BL words buffered for writing
//   rd_burst_ok         idle and at least BL free words in the read FIFO
//   busy                a burst (or its read latency) is in progress
//   cmd_err             sticky: a start pulse was ignored
//   bus                 APB FIFO handshakes and DQ pad signals (slave view)
// Build option: SDR_DQM_MASK_EN -- when defined the write FIFO carries the
// byte enables and drives dqm = ~wbe for each written beat; otherwise wbe is
// ignored and dqm is held at 0.
//
// state  | meaning
// IDLE   | waiting for a start pulse
// WBURST | driving write beats from the write FIFO onto DQ
// RLAT   | waiting out the CAS latency before the first read beat
// RBURST | sampling read beats from DQ into the read FIFO
module sdr_burst_data_path #(
  parameter int DW     = 16,
  parameter int BL     = 4,
  parameter int CL     = 2,
  parameter int WDEPTH = 8,
  parameter int RDEPTH = 8
) (
  input  logic pclk,
  input  logic preset,
  input  logic wr_start,
  input  logic rd_start,
  output logic wr_burst_ok,
  output logic rd_burst_ok,
  output logic busy,
  output logic cmd_err,
  sdr_burst_data_path_if.slave bus
);
  localparam int BW       = DW / 8;
  localparam int WAW      = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
  localparam int RAW      = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int WCW      = WAW + 1;
  localparam int RCW      = RAW + 1;
  localparam int BCW      = (BL > 1) ? $clog2(BL) : 1;
  // RLAT is held for CL-1 cycles; only meaningful when CL > 1
  localparam int LAT_LAST = (CL > 1) ? CL - 2 : 0;
`ifdef SDR_DQM_MASK_EN
  localparam int WW = DW + BW;
`else
  localparam int WW = DW;
`endif

  typedef enum logic [1:0] {IDLE, WBURST, RLAT, RBURST} state_t;

  state_t         state, state_nxt;
  logic [BCW-1:0] beat_cnt, beat_nxt;
  logic [1:0]     lat_cnt, lat_nxt;
  logic           dq_oe_q, oe_nxt;
  logic [DW-1:0]  dq_out_q;
  logic           cmd_err_q, err_set;
  logic           wpop_req, rpush_req;

  // ---------------- write FIFO ----------------
  logic [WW-1:0]  wmem [WDEPTH];
  logic [WAW-1:0] wwp, wrp;
  logic [WCW-1:0] wcnt;
  logic [WW-1:0]  wword, whead;
  logic           wfull, wempty, wpush, wpop;

`ifdef SDR_DQM_MASK_EN
  assign wword = {bus.wbe, bus.wdata};
`else
  logic unused_wbe;
  assign unused_wbe = ^bus.wbe;
  assign wword      = bus.wdata;
`endif

  assign wfull  = (wcnt == WCW'(WDEPTH));
  assign wempty = (wcnt == '0);
  // wready is "not full", so a push into a full FIFO is never accepted,
  // even if a burst pops on the same edge
  assign wpush  = bus.wvalid && !wfull;
  assign wpop   = wpop_req && !wempty;
  assign whead  = wmem[wrp];

  always_ff @(posedge pclk) begin
    if (wpush) wmem[wwp] <= wword;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wwp  <= '0;
      wrp  <= '0;
      wcnt <= '0;
    end else begin
      if (wpush) wwp <= (wwp == WAW'(WDEPTH - 1)) ? '0 : wwp + 1'b1;
      if (wpop)  wrp <= (wrp == WAW'(WDEPTH - 1)) ? '0 : wrp + 1'b1;
      case ({wpush, wpop})
        2'b10:   wcnt <= wcnt + 1'b1;
        2'b01:   wcnt <= wcnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- read FIFO ----------------
  logic [DW-1:0]  rmem [RDEPTH];
  logic [RAW-1:0] rwp, rrp;
  logic [RCW-1:0] rcnt;
  logic           rfull, rempty, rpush, rpop;

  assign rfull  = (rcnt == RCW'(RDEPTH));
  assign rempty = (rcnt == '0);
  assign rpush  = rpush_req && !rfull;
  assign rpop   = bus.rready && !rempty;

  always_ff @(posedge pclk) begin
    if (rpush) rmem[rwp] <= bus.dq_in;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rwp  <= '0;
      rrp  <= '0;
      rcnt <= '0;
    end else begin
      if (rpush) rwp <= (rwp == RAW'(RDEPTH - 1)) ? '0 : rwp + 1'b1;
      if (rpop)  rrp <= (rrp == RAW'(RDEPTH - 1)) ? '0 : rrp + 1'b1;
      case ({rpush, rpop})
        2'b10:   rcnt <= rcnt + 1'b1;
        2'b01:   rcnt <= rcnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- status ----------------
  assign wr_burst_ok = (state == IDLE) && (wcnt >= WCW'(BL));
  assign rd_burst_ok = (state == IDLE) && (rcnt <= RCW'(RDEPTH - BL));
  assign busy        = (state != IDLE);
  assign cmd_err     = cmd_err_q;

  assign bus.wready = !wfull;
  assign bus.rvalid = !rempty;
  assign bus.rdata  = rmem[rrp];
  assign bus.dq_oe  = dq_oe_q;
  assign bus.dq_out = dq_out_q;

  // ---------------- burst FSM ----------------
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    lat_nxt   = lat_cnt;
    oe_nxt    = dq_oe_q;
    wpop_req  = 1'b0;
    rpush_req = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_start) begin
          // write has priority; a simultaneous read is dropped and flagged
          if (rd_start || !wr_burst_ok) err_set = 1'b1;
          if (wr_burst_ok) begin
            state_nxt = WBURST;
            beat_nxt  = '0;
            wpop_req  = 1'b1;
            oe_nxt    = 1'b1;
          end
        end else if (rd_start) begin
          if (rd_burst_ok) begin
            beat_nxt  = '0;
            lat_nxt   = '0;
            state_nxt = (CL == 1) ? RBURST : RLAT;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      WBURST: begin
        err_set = wr_start || rd_start;
        if (beat_cnt == BCW'(BL - 1)) begin
          state_nxt = IDLE;
          oe_nxt    = 1'b0;
        end else begin
          beat_nxt = beat_cnt + 1'b1;
          wpop_req = 1'b1;
        end
      end
      RLAT: begin
        err_set = wr_start || rd_start;
        if (lat_cnt == 2'(LAT_LAST)) state_nxt = RBURST;
        else                         lat_nxt   = lat_cnt + 1'b1;
      end
      RBURST: begin
        err_set   = wr_start || rd_start;
        rpush_req = 1'b1;
        if (beat_cnt == BCW'(BL - 1)) state_nxt = IDLE;
        else                          beat_nxt  = beat_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      lat_cnt   <= '0;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      lat_cnt  <= lat_nxt;
      dq_oe_q  <= oe_nxt;
      if (wpop)    dq_out_q  <= whead[DW-1:0];
      if (err_set) cmd_err_q <= 1'b1;
    end
  end

`ifdef SDR_DQM_MASK_EN
  logic [BW-1:0] dqm_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)       dqm_q <= '0;
    else if (wpop)    dqm_q <= ~whead[WW-1:DW];
    else if (!oe_nxt) dqm_q <= '0;
  end

  assign bus.dqm = dqm_q;
`else
  assign bus.dqm = '0;
`endif
endmodule

// File: tb/tb_sdr_burst_data_path.sv
module tb_sdr_burst_data_path;
  localparam int DW = 16;
  localparam int BL = 4;
  localparam int CL = 2;
  localparam int WD = 8;
  localparam int RD = 8;
`ifdef SDR_DQM_MASK_EN
  localparam int DQM_EN = 1;
`else
  localparam int DQM_EN = 0;
`endif

  logic pclk     = 1'b0;
  logic preset   = 1'b1;
  logic wr_start = 1'b0;
  logic rd_start = 1'b0;
  logic wr_burst_ok, rd_burst_ok, busy, cmd_err;

  int errors = 0;
  int checks = 0;

  sdr_burst_data_path_if #(.DW(DW)) bus ();

  sdr_burst_data_path #(.DW(DW), .BL(BL), .CL(CL), .WDEPTH(WD), .RDEPTH(RD)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .wr_start    (wr_start),
    .rd_start    (rd_start),
    .wr_burst_ok (wr_burst_ok),
    .rd_burst_ok (rd_burst_ok),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .bus         (bus)
  );

  always #5 pclk = ~pclk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Queues hold FIFO contents; bursts are tracked as edge-number windows.
  int m_wd[$], m_wbe[$], m_rq[$];
  int m_edge, m_idle_at, m_wfirst, m_wlast, m_rfirst, m_rlast;
  int m_oe, m_dq, m_dqm, m_err;

  function automatic void model_reset();
    m_wd.delete(); m_wbe.delete(); m_rq.delete();
    m_edge = 0; m_idle_at = 0;
    m_wfirst = 1; m_wlast = 0; m_rfirst = 1; m_rlast = 0;
    m_oe = 0; m_dq = 0; m_dqm = 0; m_err = 0;
  endfunction

  function automatic int m_idle();
    return (m_edge >= m_idle_at) ? 1 : 0;
  endfunction

  // effect of the coming rising edge, given the inputs now applied
  function automatic void model_edge();
    int e    = m_edge + 1;
    int idle = m_idle();
    int wq_n = m_wd.size();
    int rq_n = m_rq.size();
    int wok  = (idle != 0 && wq_n >= BL) ? 1 : 0;
    int rok  = (idle != 0 && RD - rq_n >= BL) ? 1 : 0;
    int be;
    if (idle != 0) begin
      if (wr_start) begin
        if (wok != 0) begin
          m_wfirst = e; m_wlast = e + BL - 1; m_idle_at = e + BL;
        end else m_err = 1;
        if (rd_start) m_err = 1;
      end else if (rd_start) begin
        if (rok != 0) begin
          m_rfirst = e + CL; m_rlast = e + CL + BL - 1; m_idle_at = e + CL + BL - 1;
        end else m_err = 1;
      end
    end else if (wr_start || rd_start) m_err = 1;
    if (e >= m_wfirst && e <= m_wlast) begin
      m_oe  = 1;
      m_dq  = m_wd.pop_front();
      be    = m_wbe.pop_front();
      m_dqm = (DQM_EN != 0) ? (~be & 3) : 0;
    end else begin
      m_oe  = 0;
      m_dqm = 0;
    end
    if (bus.wvalid && wq_n < WD) begin
      m_wd.push_back(int'(bus.wdata));
      m_wbe.push_back(int'(bus.wbe));
    end
    if (bus.rready && rq_n > 0) void'(m_rq.pop_front());
    if (e >= m_rfirst && e <= m_rlast && rq_n < RD) m_rq.push_back(int'(bus.dq_in));
    m_edge = e;
  endfunction

  function automatic void check_model();
    chk("m_oe", bus.dq_oe, m_oe);
    if (m_oe != 0) chk("m_dq", bus.dq_out, m_dq);
    chk("m_dqm", bus.dqm, m_dqm);
    chk("m_busy", busy, (m_edge < m_idle_at));
    chk("m_err", cmd_err, m_err);
    chk("m_wready", bus.wready, (m_wd.size() < WD));
    chk("m_rvalid", bus.rvalid, (m_rq.size() > 0));
    if (m_rq.size() > 0) chk("m_rdata", bus.rdata, m_rq[0]);
    chk("m_wok", wr_burst_ok, (m_idle() != 0 && m_wd.size() >= BL));
    chk("m_rok", rd_burst_ok, (m_idle() != 0 && RD - m_rq.size() >= BL));
  endfunction

  // ---------------- helpers ----------------
  task automatic idle_inputs();
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wbe = '1;
    bus.rready = 1'b0; bus.dq_in = '0;
    wr_start = 1'b0; rd_start = 1'b0;
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b1;
    idle_inputs();
    @(negedge pclk);
    preset = 1'b0;
    model_reset();
  endtask

  task automatic push_word(int d, int be);
    bus.wvalid = 1'b1;
    bus.wdata  = 16'(d);
    bus.wbe    = 2'(be);
    step();
    bus.wvalid = 1'b0;
    bus.wbe    = '1;
  endtask

  typedef struct {
    int wv, wd, ws, rs, rr, dqi;
    int e_oe, e_dq, e_busy, e_rv, e_rd, e_wok;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int wv, int wd, int ws, int rs, int rr, int dqi,
                              int e_oe, int e_dq, int e_busy, int e_rv, int e_rd, int e_wok);
    vec_t v;
    v.wv = wv; v.wd = wd; v.ws = ws; v.rs = rs; v.rr = rr; v.dqi = dqi;
    v.e_oe = e_oe; v.e_dq = e_dq; v.e_busy = e_busy;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_wok = e_wok;
    tbl.push_back(v);
  endfunction

  initial begin
    int pct[4];
    int exp_w[4];

    //  wv  wd       ws rs rr dqi       oe dq       busy rv rd      wok
    add(1, 'h1111, 0, 0, 0, 0,       0, 0,       0, 0, 0,       0);
    add(1, 'h2222, 0, 0, 0, 0,       0, 0,       0, 0, 0,       0);
    add(1, 'h3333, 0, 0, 0, 0,       0, 0,       0, 0, 0,       0);
    add(1, 'h4444, 0, 0, 0, 0,       0, 0,       0, 0, 0,       1);
    add(0, 0,      1, 0, 0, 0,       1, 'h1111,  1, 0, 0,       0);
    add(0, 0,      0, 0, 0, 0,       1, 'h2222,  1, 0, 0,       0);
    add(0, 0,      0, 0, 0, 0,       1, 'h3333,  1, 0, 0,       0);
    add(0, 0,      0, 0, 0, 0,       1, 'h4444,  1, 0, 0,       0);
    add(0, 0,      0, 0, 0, 0,       0, 0,       0, 0, 0,       0);
    add(0, 0,      0, 1, 0, 'hDEAD,  0, 0,       1, 0, 0,       0);
    add(0, 0,      0, 0, 0, 'hDEAD,  0, 0,       1, 0, 0,       0);
    add(0, 0,      0, 0, 0, 'h00A0,  0, 0,       1, 1, 'hA0,    0);
    add(0, 0,      0, 0, 0, 'h00A1,  0, 0,       1, 1, 'hA0,    0);
    add(0, 0,      0, 0, 0, 'h00A2,  0, 0,       1, 1, 'hA0,    0);
    add(0, 0,      0, 0, 0, 'h00A3,  0, 0,       0, 1, 'hA0,    0);
    add(0, 0,      0, 0, 1, 'hDEAD,  0, 0,       0, 1, 'hA1,    0);
    add(0, 0,      0, 0, 1, 'hDEAD,  0, 0,       0, 1, 'hA2,    0);
    add(0, 0,      0, 0, 1, 'hDEAD,  0, 0,       0, 1, 'hA3,    0);
    add(0, 0,      0, 0, 1, 'hDEAD,  0, 0,       0, 0, 0,       0);

    idle_inputs();
    do_reset();

    // reset state
    chk("rst_oe", bus.dq_oe, 0);
    chk("rst_dq", bus.dq_out, 0);
    chk("rst_dqm", bus.dqm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_wready", bus.wready, 1);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_wok", wr_burst_ok, 0);
    chk("rst_rok", rd_burst_ok, 1);

    // T1/T2: write burst then read burst, cycle by cycle
    for (int i = 0; i < tbl.size(); i++) begin
      bus.wvalid = (tbl[i].wv != 0);
      bus.wdata  = 16'(tbl[i].wd);
      wr_start   = (tbl[i].ws != 0);
      rd_start   = (tbl[i].rs != 0);
      bus.rready = (tbl[i].rr != 0);
      bus.dq_in  = 16'(tbl[i].dqi);
      step();
      chk($sformatf("v%0d_oe", i), bus.dq_oe, tbl[i].e_oe);
      if (tbl[i].e_oe != 0) chk($sformatf("v%0d_dq", i), bus.dq_out, tbl[i].e_dq);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_rvalid", i), bus.rvalid, tbl[i].e_rv);
      if (tbl[i].e_rv != 0) chk($sformatf("v%0d_rdata", i), bus.rdata, tbl[i].e_rd);
      chk($sformatf("v%0d_wok", i), wr_burst_ok, tbl[i].e_wok);
      chk($sformatf("v%0d_wready", i), bus.wready, 1);
      chk($sformatf("v%0d_err", i), cmd_err, 0);
    end
    idle_inputs();

    // T3: start with too few words is ignored
    do_reset();
    push_word('h0301, 3);
    push_word('h0302, 3);
    push_word('h0303, 3);
    wr_start = 1'b1; step(); wr_start = 1'b0;
    chk("t3_err", cmd_err, 1);
    chk("t3_oe", bus.dq_oe, 0);
    chk("t3_busy", busy, 0);
    chk("t3_wok3", wr_burst_ok, 0);
    push_word('h0304, 3);
    chk("t3_wok4", wr_burst_ok, 1);
    exp_w = '{'h0301, 'h0302, 'h0303, 'h0304};
    wr_start = 1'b1;
    for (int b = 0; b < BL; b++) begin
      step(); wr_start = 1'b0;
      chk($sformatf("t3_oe%0d", b), bus.dq_oe, 1);
      chk($sformatf("t3_dq%0d", b), bus.dq_out, exp_w[b]);
    end
    step();
    chk("t3_oe_end", bus.dq_oe, 0);

    // T4: simultaneous starts -> write wins, error flagged
    do_reset();
    for (int k = 0; k < 4; k++) push_word('h0401 + k, 3);
    wr_start = 1'b1; rd_start = 1'b1;
    for (int b = 0; b < BL; b++) begin
      step(); wr_start = 1'b0; rd_start = 1'b0;
      chk($sformatf("t4_oe%0d", b), bus.dq_oe, 1);
      chk($sformatf("t4_dq%0d", b), bus.dq_out, 'h0401 + b);
      chk($sformatf("t4_err%0d", b), cmd_err, 1);
    end
    step();
    chk("t4_oe_end", bus.dq_oe, 0);
    chk("t4_busy_end", busy, 0);
    step(); step(); step();
    chk("t4_no_read", bus.rvalid, 0);
    // fill to full; a push while full must not be taken
    for (int k = 0; k < WD; k++) push_word('h0411 + k, 3);
    chk("t4_full_wready", bus.wready, 0);
    bus.wvalid = 1'b1; bus.wdata = 16'h0999; step(); bus.wvalid = 1'b0;
    for (int burst = 0; burst < 2; burst++) begin
      wr_start = 1'b1;
      for (int b = 0; b < BL; b++) begin
        step(); wr_start = 1'b0;
        chk($sformatf("t4_full_dq%0d_%0d", burst, b), bus.dq_out, 'h0411 + burst * BL + b);
      end
      step();
    end
    chk("t4_drained_wok", wr_burst_ok, 0);
    chk("t4_drained_wready", bus.wready, 1);

    // T5: reset in the middle of a write burst (cmd_err is set from T4)
    for (int k = 0; k < 4; k++) push_word('h0501 + k, 3);
    wr_start = 1'b1; step(); wr_start = 1'b0;
    step(); step();
    chk("t5_beat2_dq", bus.dq_out, 'h0503);
    chk("t5_err_before", cmd_err, 1);
    preset = 1'b1;
    #1;
    chk("t5_oe_async", bus.dq_oe, 0);
    @(negedge pclk);
    preset = 1'b0;
    model_reset();
    #1;
    chk("t5_wready", bus.wready, 1);
    chk("t5_rvalid", bus.rvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", cmd_err, 0);
    chk("t5_wok", wr_burst_ok, 0);

    // T6: byte mask on DQM
    do_reset();
    push_word('hBEEF, 1);
    push_word('h1234, 2);
    push_word('h5678, 3);
    push_word('h9ABC, 3);
    wr_start = 1'b1; step(); wr_start = 1'b0;
    chk("t6_dq0", bus.dq_out, 'hBEEF);
    chk("t6_dqm0", bus.dqm, (DQM_EN != 0) ? 2 : 0);
    step();
    chk("t6_dqm1", bus.dqm, (DQM_EN != 0) ? 1 : 0);
    step();
    chk("t6_dqm2", bus.dqm, 0);
    step(); step();
    chk("t6_dqm_end", bus.dqm, 0);
    chk("t6_oe_end", bus.dq_oe, 0);

    // randomized traffic against the model
    pct = '{3, 8, 15, 30};
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        bus.wvalid = ($urandom_range(0, 99) < 50);
        bus.wdata  = 16'($urandom);
        bus.wbe    = 2'($urandom);
        bus.rready = ($urandom_range(0, 99) < 40);
        bus.dq_in  = 16'($urandom);
        wr_start   = ($urandom_range(0, 99) < pct[s]);
        rd_start   = ($urandom_range(0, 99) < pct[s]);
        model_edge();
        step();
        check_model();
      end
      idle_inputs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
